// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory port arbiter: response owner encoding and the
// word-alignment mask applied to load/store addresses.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    RSP_NONE,
    RSP_IF,
    RSP_DRD,
    RSP_DWR,
    RSP_DERR
  } rsp_owner_e;

  localparam logic [1:0] ALIGN_MASK = 2'b11;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch and load/store; grant is same-cycle,
// response exactly one cycle later; requesters are held off only by withholding gnt, responses never stall.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            if_req_i,
  input  logic [XLEN-1:0] if_addr_i,
  output logic            if_gnt_o,
  output logic            if_rvalid_o,
  output logic [XLEN-1:0] if_rdata_o,
  input  logic            d_req_i,
  input  logic            d_we_i,
  input  logic [XLEN-1:0] d_addr_i,
  input  logic [XLEN-1:0] d_wdata_i,
  output logic            d_gnt_o,
  output logic            d_rvalid_o,
  output logic [XLEN-1:0] d_rdata_o,
  output logic            d_err_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic            mem_we_o,
  output logic [XLEN-1:0] mem_wdata_o,
  input  logic [XLEN-1:0] mem_rdata_i
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] starve_cnt;
  rsp_owner_e    rsp_q;
  rsp_owner_e    rsp_d;
  logic          force_if;
  logic          aligned;

  always_comb begin
    force_if = if_req_i && (starve_cnt == CW'(STARVE_MAX));
    // Gating with rstn_i keeps both grants low while reset is held.
    d_gnt_o  = rstn_i & d_req_i & ~force_if;
    if_gnt_o = rstn_i & if_req_i & ~d_gnt_o;
    aligned  = (d_addr_i[1:0] & ALIGN_MASK) == 2'b00;

    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_wdata_o = '0;
    rsp_d       = RSP_NONE;
    if (d_gnt_o) begin
      mem_addr_o  = d_addr_i;
      mem_we_o    = d_we_i & aligned;
      mem_wdata_o = d_wdata_i;
      if (!aligned)    rsp_d = RSP_DERR;
      else if (d_we_i) rsp_d = RSP_DWR;
      else             rsp_d = RSP_DRD;
    end else if (if_gnt_o) begin
      mem_addr_o  = if_addr_i;
      mem_wdata_o = d_wdata_i;
      rsp_d       = RSP_IF;
    end

    if_rvalid_o = (rsp_q == RSP_IF);
    if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
    d_rvalid_o  = (rsp_q == RSP_DRD) || (rsp_q == RSP_DWR) || (rsp_q == RSP_DERR);
    d_err_o     = (rsp_q == RSP_DERR);
    d_rdata_o   = (rsp_q == RSP_DRD) ? mem_rdata_i : '0;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rsp_q      <= RSP_NONE;
      starve_cnt <= '0;
    end else begin
      rsp_q <= rsp_d;
      // Count only D grants that make a waiting fetch wait longer.
      if (if_gnt_o || !if_req_i)
        starve_cnt <= '0;
      else if (d_gnt_o && (starve_cnt != CW'(STARVE_MAX)))
        starve_cnt <= starve_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a synchronous-read memory model.
module tb_mem_port_arbiter;

  localparam int XLEN       = 32;
  localparam int STARVE_MAX = 4;

  logic            clk_i = 1'b0;
  logic            rstn_i;
  logic            if_req_i;
  logic [XLEN-1:0] if_addr_i;
  logic            if_gnt_o;
  logic            if_rvalid_o;
  logic [XLEN-1:0] if_rdata_o;
  logic            d_req_i;
  logic            d_we_i;
  logic [XLEN-1:0] d_addr_i;
  logic [XLEN-1:0] d_wdata_i;
  logic            d_gnt_o;
  logic            d_rvalid_o;
  logic [XLEN-1:0] d_rdata_o;
  logic            d_err_o;
  logic [XLEN-1:0] mem_addr_o;
  logic            mem_we_o;
  logic [XLEN-1:0] mem_wdata_o;
  logic [XLEN-1:0] mem_rdata_i;

  mem_port_arbiter #(.XLEN(XLEN), .STARVE_MAX(STARVE_MAX)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o), .d_err_o(d_err_o),
    .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // Memory driven by the DUT, and the bench's own view of what it should contain.
  logic [XLEN-1:0] mem     [0:1023];
  logic [XLEN-1:0] ref_mem [0:1023];

  always @(posedge clk_i) begin
    if (mem_we_o) mem[mem_addr_o[11:2]] <= mem_wdata_o;
    mem_rdata_i <= mem[mem_addr_o[11:2]];
  end

  typedef struct packed {
    logic            if_v;
    logic            d_v;
    logic            err;
    logic [XLEN-1:0] if_dat;
    logic [XLEN-1:0] d_dat;
  } rsp_t;

  rsp_t rsp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   model_cnt = 0;
  logic g_if, g_d;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic check_rsp();
    rsp_t e;
    e = '0;
    if (rsp_q.size() > 0) e = rsp_q.pop_front();
    check_val("rsp_flags", {61'd0, if_rvalid_o, d_rvalid_o, d_err_o}, {61'd0, e.if_v, e.d_v, e.err});
    check_val("rsp_data", {if_rdata_o, d_rdata_o}, {e.if_dat, e.d_dat});
  endtask

  // One clock cycle: drive, check grant/memory drive and pending response, push expectation.
  task automatic step(input logic ir, input logic [XLEN-1:0] ia,
                      input logic dr, input logic dw, input logic [XLEN-1:0] da,
                      input logic [XLEN-1:0] dwd);
    logic            exp_d, exp_if, exp_we, mis;
    logic [XLEN-1:0] exp_addr, exp_wd;
    rsp_t            e;
    if_req_i = ir; if_addr_i = ia;
    d_req_i = dr; d_we_i = dw; d_addr_i = da; d_wdata_i = dwd;
    @(negedge clk_i);
    check_rsp();
    exp_d    = dr && !(ir && model_cnt == STARVE_MAX);
    exp_if   = ir && !exp_d;
    mis      = (da[1:0] != 2'b00);
    exp_we   = exp_d && dw && !mis;
    exp_addr = exp_d ? da : (exp_if ? ia : '0);
    exp_wd   = (exp_d || exp_if) ? dwd : '0;
    g_if = if_gnt_o; g_d = d_gnt_o;
    check_val("gnt", {62'd0, if_gnt_o, d_gnt_o}, {62'd0, exp_if, exp_d});
    check_val("mem_drive", {31'd0, mem_we_o, mem_addr_o}, {31'd0, exp_we, exp_addr});
    check_val("mem_wdata", {32'd0, mem_wdata_o}, {32'd0, exp_wd});
    e = '0;
    if (exp_if) begin
      e.if_v = 1'b1; e.if_dat = ref_mem[ia[11:2]];
    end else if (exp_d) begin
      e.d_v = 1'b1;
      if (mis) e.err = 1'b1;
      else if (dw) ref_mem[da[11:2]] = dwd;
      else e.d_dat = ref_mem[da[11:2]];
    end
    rsp_q.push_back(e);
    if (exp_if || !ir) model_cnt = 0;
    else if (exp_d && model_cnt < STARVE_MAX) model_cnt++;
    @(posedge clk_i); #1;
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i] = 32'hA500_0000 | i; ref_mem[i] = 32'hA500_0000 | i;
    end
    mem[32'h10 >> 2] = 32'h0050_0093; ref_mem[32'h10 >> 2] = 32'h0050_0093;

    rstn_i = 1'b0;
    if_req_i = 1'b0; if_addr_i = '0; d_req_i = 1'b0; d_we_i = 1'b0; d_addr_i = '0; d_wdata_i = '0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check_val("reset_ctrl", {57'd0, if_gnt_o, if_rvalid_o, d_gnt_o, d_rvalid_o, d_err_o, mem_we_o, 1'b0},
              64'd0);
    check_val("reset_addr", {mem_addr_o, mem_wdata_o}, 64'd0);
    @(posedge clk_i); #1;
    rstn_i = 1'b1;
    idle();

    // IF only
    step(1'b1, 32'h10, 1'b0, 1'b0, '0, '0);
    idle();
    // D write then read, with a misaligned write in between
    step(1'b0, '0, 1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF);
    step(1'b0, '0, 1'b1, 1'b0, 32'h100, '0);
    step(1'b0, '0, 1'b1, 1'b1, 32'h102, 32'h1234_5678);
    step(1'b0, '0, 1'b1, 1'b0, 32'h100, '0);
    step(1'b0, '0, 1'b1, 1'b0, 32'h101, '0);
    idle();

    // Starvation: both requesting continuously
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 32'h20 + 32'(4 * i), 1'b1, 1'b0, 32'h300 + 32'(4 * i), '0);
      check_val("starve_order", {62'd0, g_if, g_d}, (i % 5 == 4) ? 64'd2 : 64'd1);
    end
    idle();

    // Back-to-back alternation
    step(1'b1, 32'h0, 1'b0, 1'b0, '0, '0);
    step(1'b0, '0, 1'b1, 1'b0, 32'h200, '0);
    step(1'b1, 32'h4, 1'b0, 1'b0, '0, '0);
    idle();

    // Reset mid-op: build up the counter, then reset right after a D read grant
    step(1'b1, 32'h8, 1'b1, 1'b0, 32'h40, '0);
    if_req_i = 1'b1; d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h44;
    @(negedge clk_i);
    check_rsp();
    check_val("pre_reset_gnt", {63'd0, d_gnt_o}, 64'd1);
    rstn_i = 1'b0;
    rsp_q.delete();
    model_cnt = 0;
    @(posedge clk_i); #1;
    @(negedge clk_i);
    check_val("inrst_ctrl", {57'd0, if_gnt_o, if_rvalid_o, d_gnt_o, d_rvalid_o, d_err_o, mem_we_o, 1'b0},
              64'd0);
    check_val("inrst_rdata", {if_rdata_o, d_rdata_o}, 64'd0);
    check_val("inrst_mem", {mem_addr_o, mem_wdata_o}, 64'd0);
    @(posedge clk_i); #1;
    rstn_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 32'h60, 1'b1, 1'b0, 32'h80, '0);
      check_val("post_rst_order", {62'd0, g_if, g_d}, (i == 4) ? 64'd2 : 64'd1);
    end
    idle();
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
